// File: rtl/mux4_sel_ctrl_if.sv
// Handshake and select bundle between the round-robin sequencer, its requesters,
// the downstream 4:1 mux and the sample consumer.
interface mux4_sel_ctrl_if #(
  parameter int DWELL_W = 4
);
  logic               en;
  logic [3:0]         req;
  logic [DWELL_W-1:0] dwell;
  logic               ready;
  logic               s1;
  logic               s0;
  logic [3:0]         grant;
  logic               valid;
  logic               busy;

  // The sequencer itself drives the mux selects and the presentation handshake.
  modport master (
    input  en, req, dwell, ready,
    output s1, s0, grant, valid, busy
  );

  modport slave (
    output en, req, dwell, ready,
    input  s1, s0, grant, valid, busy
  );
endinterface

// File: rtl/mux4_sel_ctrl.sv
// Round-robin channel sequencer for a 4:1 mux: grants a channel, holds the
// registered selects for a programmable dwell, then presents with valid/ready.
module mux4_sel_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux4_sel_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         r_sel;
  logic [1:0]         r_last_ch;
  logic [3:0]         r_grant;
  logic               r_valid;

  state_t             w_state_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [1:0]         w_sel_nxt;
  logic [1:0]         w_last_nxt;
  logic [3:0]         w_grant_nxt;
  logic               w_valid_nxt;
  logic               w_start;
  logic [1:0]         w_pick_base;
  logic [1:0]         w_pick;

  // First set request bit at or after (last + 1), wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last + 2'd1;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req_v[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last_ch;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_start     = 1'b0;
    w_pick_base = r_last_ch;

    unique case (r_state)
      ST_IDLE: begin
        w_start = bus.en && (|bus.req);
      end
      ST_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else begin
          w_state_nxt = ST_PRESENT;
          w_valid_nxt = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (bus.ready) begin
          // The pointer advances on this edge, so a back-to-back pick already uses it.
          w_last_nxt  = r_sel;
          w_pick_base = r_sel;
          w_valid_nxt = 1'b0;
          w_grant_nxt = 4'b0000;
          w_state_nxt = ST_IDLE;
          w_start     = bus.en && (|bus.req);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase

    w_pick = rr_pick(bus.req, w_pick_base);

    if (w_start) begin
      w_state_nxt = ST_HOLD;
      w_sel_nxt   = w_pick;
      w_grant_nxt = 4'b0001 << w_pick;
      w_cnt_nxt   = bus.dwell;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= 2'd0;
      r_last_ch <= 2'd3;
      r_grant   <= 4'b0000;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_last_ch <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign bus.s1    = r_sel[1];
  assign bus.s0    = r_sel[0];
  assign bus.grant = r_grant;
  assign bus.valid = r_valid;
  assign bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux4_sel_ctrl.sv
// Self-checking bench for mux4_sel_ctrl: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mux4_sel_ctrl;

  localparam int DWELL_W = 4;

  logic clk;
  logic rst_n;

  mux4_sel_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  mux4_sel_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one transaction at a time, tracked by its age since grant.
  bit m_active;
  int m_ch;
  int m_sel;
  int m_last;
  int m_age;
  int m_dwell;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_ch     = 0;
    m_sel    = 0;
    m_last   = 3;
    m_age    = 0;
    m_dwell  = 0;
  endtask

  task automatic model_grant();
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (bus.req[c]) begin
        m_ch     = c;
        m_sel    = c;
        m_active = 1'b1;
        m_age    = 0;
        m_dwell  = int'(bus.dwell);
        break;
      end
    end
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (bus.en && bus.req != 4'b0000) model_grant();
    end else if (m_age > m_dwell) begin
      if (bus.ready) begin
        m_last   = m_ch;
        m_active = 1'b0;
        if (bus.en && bus.req != 4'b0000) model_grant();
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_all(input string ph);
    logic [3:0] exp_grant;
    logic       exp_valid;
    exp_grant = m_active ? (4'b0001 << m_ch) : 4'b0000;
    exp_valid = m_active && (m_age > m_dwell);
    check({ph, ".grant"}, bus.grant, exp_grant);
    check({ph, ".sel"}, {bus.s1, bus.s0}, m_sel);
    check({ph, ".valid"}, bus.valid, exp_valid);
    check({ph, ".busy"}, bus.busy, m_active);
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic e, input logic [3:0] r, input logic [3:0] d, input logic rd);
    bus.en    = e;
    bus.req   = r;
    bus.dwell = d;
    bus.ready = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 4'b0000, 4'd0, 1'b0);
    model_reset();
    @(negedge clk);
    compare_all("por");
    rst_n = 1'b1;

    // 1: single grant of channel 2 with dwell 2
    set_in(1'b1, 4'b0100, 4'd2, 1'b1);
    tick("t1.grant");
    check("t1.sel_grant", {bus.s1, bus.s0, bus.grant, bus.busy}, {2'b10, 4'b0100, 1'b1});
    bus.req = 4'b0000;
    tick("t1.h1");
    tick("t1.h2");
    check("t1.not_yet_valid", bus.valid, 1'b0);
    tick("t1.present");
    check("t1.valid", bus.valid, 1'b1);
    tick("t1.idle");
    check("t1.idle", {bus.grant, bus.valid, bus.busy}, 6'b0);

    // 2: all requesting, dwell 0 -> 0,1,2,3,0,1 back-to-back
    do_reset();
    set_in(1'b1, 4'b1111, 4'd0, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      tick("t2");
      check("t2.order", bus.grant, 4'b0001 << (((t - 1) / 2) % 4));
      check("t2.no_bubble", bus.busy, 1'b1);
    end

    // 3: req 1010, dwell 1 -> 1,3,1,3
    do_reset();
    set_in(1'b1, 4'b1010, 4'd1, 1'b1);
    for (int t = 1; t <= 12; t++) begin
      tick("t3");
      check("t3.order", {bus.s1, bus.s0}, ((((t - 1) / 3) % 2) == 1) ? 2'b11 : 2'b01);
    end

    // 4: consumer stalls, req changes underneath, then wrap to channel 0
    do_reset();
    set_in(1'b1, 4'b0100, 4'd0, 1'b0);
    tick("t4.grant");
    tick("t4.present");
    bus.req = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      tick("t4.stall");
      check("t4.stall_hold", {bus.valid, bus.s1, bus.s0}, 3'b110);
    end
    bus.ready = 1'b1;
    tick("t4.handoff");
    check("t4.next_ch0", {bus.grant, bus.valid}, {4'b0001, 1'b0});

    // 5: asynchronous reset during HOLD of channel 1
    do_reset();
    set_in(1'b1, 4'b0001, 4'd0, 1'b1);
    tick("t5.g0");
    tick("t5.p0");
    set_in(1'b1, 4'b1111, 4'd3, 1'b1);
    tick("t5.g1");
    check("t5.ch1", bus.grant, 4'b0010);
    tick("t5.hold");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.async_clear", {bus.s1, bus.s0, bus.grant, bus.valid, bus.busy}, 9'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick("t5.after");
    check("t5.first_ch0", bus.grant, 4'b0001);

    // 6: en dropped during HOLD; transaction still completes, then idle
    do_reset();
    set_in(1'b1, 4'b1000, 4'd3, 1'b1);
    tick("t6.grant");
    check("t6.ch3", bus.grant, 4'b1000);
    set_in(1'b0, 4'b1111, 4'd3, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      tick("t6.hold");
      check("t6.valid_timing", bus.valid, (t == 4) ? 1'b1 : 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      tick("t6.idle");
      check("t6.no_grant", bus.busy, 1'b0);
    end
    bus.en = 1'b1;
    tick("t6.resume");
    check("t6.resume_ch0", bus.grant, 4'b0001);

    // Random traffic against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.req   = 4'($urandom_range(0, 15));
      bus.dwell = 4'($urandom_range(0, 4));
      bus.ready = ($urandom_range(0, 2) != 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux4_sel_ctrl.md
Name: mux4_sel_ctrl

Overview:
- Round-robin channel sequencer that drives the select lines of the 4:1 dataflow mux directly downstream of it.
- Arbitrates four request lines and holds the selected channel stable for a programmable settle (dwell) time.
- After the dwell, presents the sample to the consumer with a valid/ready handshake.
- Select outputs are registered, so the mux sees glitch-free selects.

Parameters:
- DWELL_W, 4, width of the dwell input and of the internal dwell down-counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enables new grants; does not abort a grant in progress.
- req  input  4  per-channel request; bit i requests mux input i.
- dwell  input  DWELL_W  settle cycles minus one; captured at grant.
- ready  input  1  consumer accepts the presented sample.
- s1  output  1  mux select MSB.
- s0  output  1  mux select LSB.
- grant  output  4  one-hot copy of the selected channel; 0 when IDLE.
- valid  output  1  selected channel settled, sample presentable.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst_n low, including mid-operation):
  - state=IDLE, {s1,s0}=00, grant=0000, valid=0, busy=0.
  - Dwell counter=0.
  - last_ch=3, so the first grant favours channel 0.
- States: IDLE, HOLD, PRESENT.
- IDLE:
  - If en=1 and |req=1 at a clock edge, pick a channel and go to HOLD on that edge.
  - On the same edge: {s1,s0}=channel, grant=onehot(channel), counter=dwell, busy=1.
  - Otherwise remain in IDLE.
- Channel pick (round robin):
  - Search req starting at (last_ch+1) mod 4 and wrap upward: 3 wraps to 0.
  - The first set bit wins.
  - last_ch updates only on a completed handshake.
- HOLD:
  - If counter != 0, decrement it.
  - If counter == 0, go to PRESENT and set valid=1 on that edge.
  - HOLD therefore lasts dwell+1 cycles; dwell=0 gives 1 cycle.
  - Total latency from the grant edge to valid high is dwell+1 edges.
- PRESENT:
  - valid=1; s1, s0 and grant are held stable.
  - valid & ready at an edge completes the transfer and sets last_ch=granted channel.
  - After the transfer, if en=1 and any req bit is set (with the new pointer), grant the next channel on that same edge: straight to HOLD, valid=0, back-to-back with no IDLE bubble.
  - Otherwise go to IDLE: grant=0000, valid=0, busy=0. {s1,s0} keeps its last value.
  - ready=0 holds PRESENT indefinitely.
- req and dwell are sampled only at grant. Dropping or changing req during HOLD or PRESENT has no effect on the current transaction.
- en=0 during HOLD or PRESENT lets the current transaction complete, then the block goes to IDLE.
- ready outside PRESENT is ignored.
- Invariants:
  - grant is always one-hot or zero.
  - grant != 0 exactly when busy=1.
  - {s1,s0} == index of grant whenever busy=1.
  - valid=1 only in PRESENT.
- No combinational path from any input to any output.

Test Plan:
1. rst_n released, en=1, req=0100, dwell=2, ready=1 → next edge {s1,s0}=10, grant=0100, busy=1. valid=1 three edges later and lasts one cycle. Then IDLE, grant=0000, busy=0.
2. req=1111 held, dwell=0, ready=1 → grants in order 0,1,2,3,0,1, each channel HOLD 1 cycle plus PRESENT 1 cycle, no IDLE between grants.
3. req=1010 held, dwell=1, ready=1 → grant order 1,3,1,3; {s1,s0}=01,11,01,11; channels 0 and 2 never selected.
4. Grant ch2, dwell=0, ready=0 for 5 cycles while req changes to 0001 → valid stays 1, {s1,s0}=10 stable. ready=1 → handshake, next grant ch0 (pointer 3 wraps to 0).
5. req=1111, rst_n pulled low during HOLD of ch1 → s1, s0, grant, valid, busy go to 0 before the next clk edge. After release, first grant is ch0.
6. Grant ch3 with dwell=3, en dropped to 0 during HOLD with req=1111 → valid still asserts after 4 cycles. Handshake completes, then IDLE, no further grant until en=1.
